game_highscore_table: RTL
=========================

Name: game_highscore_table

Overview:
- Sits directly downstream of the stacker game core and consumes its end-of-game flag plus the packed {userid, score} word.
- On each new end-of-game, inserts the result into a sorted top-DEPTH leaderboard (descending score).
- Exposes the leaderboard through a registered read port for the menu/display logic, plus a new-record pulse and a games-played counter.

Parameters:
- DEPTH, 4, number of leaderboard entries (2..8)
- UID_W, 16, user id width, game_data[31:16]
- SCORE_W, 16, score width, game_data[15:0]

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- game_eog  input  1  end-of-game level from game core; held high until the game restarts
- game_data  input  32  {userid[15:0], score[15:0]}, sampled on the eog rising edge
- rd_idx  input  3  leaderboard read index, 0 = best
- rd_entry  output  32  {userid, score} at rd_idx, registered
- rd_valid  output  1  entry at rd_idx is occupied, registered
- busy  output  1  high in SCAN and INSERT
- new_high  output  1  one-cycle pulse when an entry lands at index 0
- games_played  output  16  saturating count of captured games

Behaviour:
- Reset (rst=0 at a clk edge):
  - all entries invalid/zero; rd_entry=0, rd_valid=0, busy=0, new_high=0, games_played=0; state IDLE.
  - Edge-detect register eog_q resets to 1, so an eog already high after reset is not captured.
  - Reset mid-SCAN/INSERT aborts; the candidate is discarded.
- Edge detect: rise = game_eog & ~eog_q; eog_q <= game_eog every cycle.
- IDLE:
  - On rise, latch cand <= game_data, idx <= 0, pos <= DEPTH (none), games_played++ (saturates at 0xFFFF), go SCAN.
- SCAN (one entry per cycle, at idx):
  - Hit when entry[idx] is invalid OR cand.score > entry[idx].score (strict; ties keep the older entry ahead).
  - First hit sets pos <= idx.
  - Without the optional feature, a hit goes to INSERT immediately.
  - Reaching idx == DEPTH-1 with no hit returns to IDLE; the table is unchanged.
- INSERT (single cycle):
  - entry[pos] <= cand; entry[j] <= entry[j-1] for pos < j < DEPTH; the last entry drops off.
  - new_high <= (pos == 0). Return to IDLE.
- Latency: rise cycle to table updated = (pos+1) SCAN cycles + 1 INSERT cycle; worst case DEPTH+1 cycles.
- Rises during busy are ignored, not queued.
- Read port: rd_entry/rd_valid reflect entry[rd_idx] one cycle after rd_idx is presented. rd_idx >= DEPTH returns 0 / valid=0.
- Read during INSERT returns the pre-insert value that cycle and the post-insert value the next cycle.

Optional Feature:
- Macro: GAME_HIGHSCORE_UNIQUE_UID_EN.
- With the macro:
  - SCAN always visits all DEPTH entries and records match k = the first valid entry with userid == cand.userid.
  - If a match exists and cand.score <= entry[k].score: discard, go to IDLE, no new_high.
  - If a match exists and cand.score is higher: INSERT shifts only pos..k-1 down by one, writes entry[pos] <= cand, and leaves entries after k unchanged (no drop-off).
  - If there is no match, behaviour is the same as without the macro.
  - Latency is fixed at DEPTH+1 cycles.
- Without the macro: duplicate userids are allowed; the early-exit SCAN described above applies.

Decomposition:
- Package game_pkg:
  - hs_entry_t struct {valid, uid[UID_W], score[SCORE_W]}
  - state enum {IDLE, SCAN, INSERT}
  - GAME_DATA_W=32
- Sub-module edge_rise_det: one-flop rising-edge detector with reset value parameter RST_VAL (1 here); reusable for button inputs.

Test Plan:
- Reset, then drive eog high, then pulse rst low for 1 cycle with eog still high -> no capture, games_played=0, all rd_valid=0.
- Empty table, eog rise with data 0x1234_0005 -> busy for 2 cycles, new_high pulses, rd_idx=0 returns 0x12340005 valid.
- Scores 9,7,5,3 loaded, new game 0xAAAA_0006 -> table 9,7,6,5; 3 dropped; no new_high; insert 4 cycles after rise.
- Full table 9,7,5,3, new score 3 (tie) and then 2 -> table unchanged; games_played increments both times.
- GAME_HIGHSCORE_UNIQUE_UID_EN set, uid 0x0001 holds score 5 at idx 2, same uid scores 8 then 4 -> first gives 9,8,7,3 (old 5 removed, 3 kept); second is discarded.
- Reset asserted during SCAN -> table cleared, busy=0 the next cycle, a later eog rise is processed normally.

Source files
------------

// File: rtl/game_highscore_table_pkg.sv
// Shared types and widths for the high-score leaderboard that sits behind the stacker game core.
package game_pkg;

  localparam int GAME_DATA_W = 32;
  localparam int UID_W       = 16;
  localparam int SCORE_W     = 16;

  typedef struct packed {
    logic               valid;
    logic [UID_W-1:0]   uid;
    logic [SCORE_W-1:0] score;
  } hs_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    INSERT
  } state_t;

endpackage

// File: rtl/game_highscore_table_if.sv
// Game-core / menu-side bundle of the leaderboard: eog capture input, read port and status outputs.
interface game_highscore_table_if;
  import game_pkg::*;

  logic                   game_eog;
  logic [GAME_DATA_W-1:0] game_data;
  logic [2:0]             rd_idx;
  logic [GAME_DATA_W-1:0] rd_entry;
  logic                   rd_valid;
  logic                   busy;
  logic                   new_high;
  logic [15:0]            games_played;

  modport master (
    output game_eog, game_data, rd_idx,
    input  rd_entry, rd_valid, busy, new_high, games_played
  );

  modport slave (
    input  game_eog, game_data, rd_idx,
    output rd_entry, rd_valid, busy, new_high, games_played
  );

endinterface

// File: rtl/game_highscore_table_edge_rise_det.sv
// One-flop rising-edge detector; RST_VAL=1 suppresses a spurious edge on a level already high at reset.
module edge_rise_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) d_q <= RST_VAL;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_highscore_table.sv
// Sorted top-DEPTH leaderboard fed by the game core's end-of-game flag.
// Define GAME_HIGHSCORE_UNIQUE_UID_EN to keep at most one entry per user id.
module game_highscore_table
  import game_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  game_highscore_table_if.slave bus
);

  localparam int         MAX_DEPTH = 8;
  localparam logic [3:0] NONE      = 4'(DEPTH);
  localparam logic [2:0] LAST_IDX  = 3'(DEPTH - 1);

  state_t     state;
  hs_entry_t  entries [MAX_DEPTH];
  hs_entry_t  cand;
  logic [2:0] idx;
  logic [3:0] pos;
  logic [3:0] pos_n;
  logic [3:0] shift_lim;
  logic       rise;
  logic       scan_hit;
`ifdef GAME_HIGHSCORE_UNIQUE_UID_EN
  logic [3:0] k;
  logic [3:0] k_n;
  logic       dup_lose;
`endif

  edge_rise_det #(.RST_VAL(1'b1)) u_eog_det (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.game_eog),
    .rise (rise)
  );

  // Strict compare: on a tie the older entry stays ahead of the candidate.
  always_comb begin
    scan_hit = !entries[idx].valid || (cand.score > entries[idx].score);
    pos_n    = pos;
    if (scan_hit && pos == NONE) pos_n = {1'b0, idx};
`ifdef GAME_HIGHSCORE_UNIQUE_UID_EN
    k_n = k;
    if (entries[idx].valid && entries[idx].uid == cand.uid && k == NONE) k_n = {1'b0, idx};
    dup_lose  = (k_n != NONE) && (cand.score <= entries[k_n[2:0]].score);
    shift_lim = (k == NONE) ? 4'(DEPTH - 1) : k;
`else
    shift_lim = 4'(DEPTH - 1);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      cand             <= '0;
      idx              <= '0;
      pos              <= NONE;
`ifdef GAME_HIGHSCORE_UNIQUE_UID_EN
      k                <= NONE;
`endif
      for (int j = 0; j < MAX_DEPTH; j++) entries[j] <= '0;
      bus.rd_entry     <= '0;
      bus.rd_valid     <= 1'b0;
      bus.busy         <= 1'b0;
      bus.new_high     <= 1'b0;
      bus.games_played <= '0;
    end else begin
      bus.new_high <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            cand  <= {1'b1, bus.game_data};
            idx   <= '0;
            pos   <= NONE;
`ifdef GAME_HIGHSCORE_UNIQUE_UID_EN
            k     <= NONE;
`endif
            if (bus.games_played != 16'hFFFF) bus.games_played <= bus.games_played + 16'd1;
            state    <= SCAN;
            bus.busy <= 1'b1;
          end
        end
        SCAN: begin
          pos <= pos_n;
          idx <= idx + 3'd1;
`ifdef GAME_HIGHSCORE_UNIQUE_UID_EN
          // The whole table must be seen before we know whether this uid already holds a better score.
          k <= k_n;
          if (idx == LAST_IDX) begin
            if (!dup_lose && pos_n != NONE) begin
              state <= INSERT;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
`else
          if (scan_hit) begin
            state <= INSERT;
          end else if (idx == LAST_IDX) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
`endif
        end
        INSERT: begin
          // Entries between pos and shift_lim slide down one slot; anything past shift_lim is untouched.
          for (int j = 0; j < MAX_DEPTH; j++) begin
            if (4'(j) == pos) entries[j] <= cand;
            else if (4'(j) > pos && 4'(j) <= shift_lim) entries[j] <= entries[(j == 0) ? 0 : j - 1];
          end
          bus.new_high <= (pos == 4'd0);
          state        <= IDLE;
          bus.busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase

      if (bus.rd_idx <= LAST_IDX) begin
        bus.rd_entry <= {entries[bus.rd_idx].uid, entries[bus.rd_idx].score};
        bus.rd_valid <= entries[bus.rd_idx].valid;
      end else begin
        bus.rd_entry <= '0;
        bus.rd_valid <= 1'b0;
      end
    end
  end

endmodule
